vl_result_collector: RTL
========================

Name: vl_result_collector

Overview:
- Receiving end of the per-lane result valid protocol. Lanes shift results out with a per-lane valid mask: full masks on every beat except the last, where the mask is a contiguous low-lane mask of vl mod VLANE_NUM.
- This block consumes those beats for one vector instruction of length vl, checks each mask against what vl implies, and packs the data into a strobe-qualified stream for the store/writeback path.
- It signals completion and protocol errors to the vector control unit.

Parameters:
VLANE_NUM, 8, number of vector lanes (power of two).
MAX_VL_PER_LANE, 256, maximum elements per lane.
DATA_WIDTH, 32, element width in bits.

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous, active-high reset
start_i  in  1  begin collection for one instruction; honoured only in IDLE
vl_i  in  $clog2(VLANE_NUM*MAX_VL_PER_LANE)  vector length, sampled on accepted start_i
lane_valid_i  in  VLANE_NUM  per-lane valid mask of the current beat; bit i = lane i
lane_data_i  in  VLANE_NUM*DATA_WIDTH  lane i data at bits [i*DATA_WIDTH +: DATA_WIDTH]
lane_ready_o  out  1  collector can accept a beat this cycle
out_valid_o  out  1  output beat valid
out_data_o  out  VLANE_NUM*DATA_WIDTH  packed beat data
out_strb_o  out  VLANE_NUM  per-element write strobe
out_last_o  out  1  final beat of the instruction
out_ready_i  in  1  downstream accepts the beat
busy_o  out  1  state != IDLE
done_o  out  1  one-cycle completion pulse
err_o  out  1  sticky protocol-error flag

Behaviour:
- Reset (rst_i=1 at a clock edge):
  - State goes to IDLE; the FIFO and counters are cleared.
  - All outputs are 0 except lane_ready_o, which is 0 in IDLE.
  - Reset mid-collection drops all buffered beats with no done_o.
- Arithmetic on start:
  - div = vl >> log2(VLANE_NUM); mod = vl[log2(VLANE_NUM)-1:0].
  - total_beats = div + (mod != 0).
  - last_mask = (mod == 0) ? all-ones : (1 << mod) - 1.
  - The beat counter is wide enough to hold MAX_VL_PER_LANE.
- States:
  - IDLE:
    - On start_i with vl == 0: go to DONE with no beats emitted.
    - On start_i otherwise: latch total_beats and last_mask, clear beat_cnt and err_o, go to COLLECT.
    - Any lane_valid_i != 0 while in IDLE sets err_o; the data is discarded.
  - COLLECT:
    - lane_ready_o = FIFO not full.
    - A beat is accepted when lane_valid_i != 0 and lane_ready_o = 1.
    - exp_mask = (beat_cnt == total_beats-1) ? last_mask : all-ones.
    - If lane_valid_i != exp_mask, set err_o. The beat is still pushed, with strobe = exp_mask (never the received mask).
    - The final beat is pushed with last = 1; after it, go to DRAIN.
    - Beats with lane_valid_i = 0 are idle cycles, not errors.
  - DRAIN:
    - lane_ready_o = 0; any lane_valid_i != 0 here sets err_o.
    - When the FIFO is empty and no pop is in progress, go to DONE.
  - DONE:
    - done_o = 1 for exactly one cycle, then IDLE.
    - start_i is ignored in DONE; it is accepted the next cycle.
- Buffering:
  - 2-entry FIFO of {data, strb, last}.
  - Latency: a beat accepted at edge N is visible on out_* after edge N (registered output).
  - Sustains 1 beat/cycle with out_ready_i held at 1.
  - Pop when out_valid_o && out_ready_i.
  - Simultaneous push and pop is legal when full.
  - out_data_o, out_strb_o and out_last_o hold stable while out_valid_o=1 and out_ready_i=0.
- Other rules:
  - start_i outside IDLE is ignored, with no error.
  - err_o stays set until the next accepted start_i or reset.

Decomposition:
- Shared vector-core package holds:
  - the state enum (IDLE, COLLECT, DRAIN, DONE);
  - a function that computes last_mask from vl and VLANE_NUM (the same rule the sending side uses, so there is a single definition).
- One sub-module: vrc_fifo2, a parameterised 2-entry synchronous FIFO with full/empty flags.

Test Plan:
- vl=19, lanes send masks 0xFF, 0xFF, 0x07 back-to-back, out_ready_i=1:
  - three output beats with strb 0xFF, 0xFF, 0x07;
  - out_last_o on the third beat only;
  - done_o pulses once; err_o=0.
- vl=16 -> two beats with strb 0xFF, out_last_o on the second; vl=0 -> done_o pulse, out_valid_o never asserted.
- vl=40, out_ready_i=0 for 6 cycles from the first beat:
  - lane_ready_o drops after 2 beats are accepted;
  - no beat is lost or duplicated; data order is preserved after release.
- vl=19, final beat mask 0x0F -> err_o=1, out_strb_o=0x07 on the last beat, done_o still pulses; err_o clears on the next start_i.
- vl=24, rst_i asserted after the second beat:
  - next cycle all outputs are 0 and busy_o=0;
  - a new start_i with vl=8 completes normally with strb 0xFF.
- lane_valid_i=0x01 in IDLE -> err_o=1; start_i pulsed during COLLECT -> ignored, vl unchanged.

Source files
------------

// File: rtl/vl_result_collector_pkg.sv
// Shared vector-core definitions: collector state encoding and the last-beat
// lane mask rule that both the sending lanes and the collector rely on.
package vl_result_collector_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_DRAIN   = 2'd2,
      ST_DONE    = 2'd3
   } vrc_state_e;

   // Lane 'lane' is valid on the final beat when vl mod lanes is zero (full beat)
   // or the lane index is below that remainder.
   function automatic logic lane_in_last_mask(input logic [31:0] vl,
                                              input int unsigned lanes,
                                              input int unsigned lane);
      logic [31:0] vl_mod;
      vl_mod = vl & (lanes - 32'd1);
      return (vl_mod == 32'd0) || (lane < vl_mod);
   endfunction

endpackage

// File: rtl/vrc_fifo2.sv
// Two-entry synchronous FIFO with full/empty flags; read data comes straight
// from the storage registers so it is stable while the head entry waits.
module vrc_fifo2 #(
   parameter int WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] data_o,
   output logic             full_o,
   output logic             empty_o
);

   logic [WIDTH-1:0] mem [2];
   logic             wr_ptr_reg;
   logic             rd_ptr_reg;
   logic [1:0]       count_reg;
   logic             do_push;
   logic             do_pop;

   assign full_o  = (count_reg == 2'd2);
   assign empty_o = (count_reg == 2'd0);

   // A push into a full FIFO is legal only when the head leaves in the same cycle.
   assign do_push = push_i && (!full_o || pop_i);
   assign do_pop  = pop_i && !empty_o;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_reg <= 1'b0;
         rd_ptr_reg <= 1'b0;
         count_reg  <= 2'd0;
      end else begin
         if (do_push) wr_ptr_reg <= ~wr_ptr_reg;
         if (do_pop)  rd_ptr_reg <= ~rd_ptr_reg;
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + 2'd1;
            2'b01:   count_reg <= count_reg - 2'd1;
            default: count_reg <= count_reg;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem[wr_ptr_reg] <= data_i;
   end

   assign data_o = mem[rd_ptr_reg];

endmodule

// File: rtl/vl_result_collector.sv
// Collects per-lane result beats for one vector instruction, checks each valid
// mask against vl, and emits a strobe-qualified stream plus done/error status.
module vl_result_collector
   import vl_result_collector_pkg::*;
#(
   parameter int VLANE_NUM       = 8,
   parameter int MAX_VL_PER_LANE = 256,
   parameter int DATA_WIDTH      = 32
) (
   input  logic                                       clk_i,
   input  logic                                       rst_i,
   input  logic                                       start_i,
   input  logic [$clog2(VLANE_NUM*MAX_VL_PER_LANE)-1:0] vl_i,
   input  logic [VLANE_NUM-1:0]                       lane_valid_i,
   input  logic [VLANE_NUM*DATA_WIDTH-1:0]            lane_data_i,
   output logic                                       lane_ready_o,
   output logic                                       out_valid_o,
   output logic [VLANE_NUM*DATA_WIDTH-1:0]            out_data_o,
   output logic [VLANE_NUM-1:0]                       out_strb_o,
   output logic                                       out_last_o,
   input  logic                                       out_ready_i,
   output logic                                       busy_o,
   output logic                                       done_o,
   output logic                                       err_o
);

   localparam int VL_W    = $clog2(VLANE_NUM*MAX_VL_PER_LANE);
   localparam int LANE_W  = $clog2(VLANE_NUM);
   localparam int BEAT_W  = $clog2(MAX_VL_PER_LANE + 1);
   localparam int BUS_W   = VLANE_NUM*DATA_WIDTH;
   localparam int ENTRY_W = BUS_W + VLANE_NUM + 1;

   vrc_state_e           state_reg, state_next;
   logic [BEAT_W-1:0]    total_beats_reg, total_beats_next;
   logic [BEAT_W-1:0]    beat_cnt_reg, beat_cnt_next;
   logic [VLANE_NUM-1:0] last_mask_reg, last_mask_next;
   logic                 err_reg, err_next;

   logic [VL_W-LANE_W-1:0] vl_div;
   logic [LANE_W-1:0]      vl_mod;
   logic [BEAT_W-1:0]      total_beats_calc;
   logic [VLANE_NUM-1:0]   last_mask_calc;

   logic                 is_final_beat;
   logic [VLANE_NUM-1:0] exp_mask;
   logic                 beat_accept;

   logic               fifo_push;
   logic               fifo_pop;
   logic [ENTRY_W-1:0] fifo_din;
   logic [ENTRY_W-1:0] fifo_dout;
   logic               fifo_full;
   logic               fifo_empty;

   assign vl_div           = vl_i[VL_W-1:LANE_W];
   assign vl_mod           = vl_i[LANE_W-1:0];
   assign total_beats_calc = BEAT_W'(vl_div) + BEAT_W'(vl_mod != '0);

   for (genvar gi = 0; gi < VLANE_NUM; gi++) begin : g_last_mask
      assign last_mask_calc[gi] = lane_in_last_mask(32'(vl_i), VLANE_NUM, gi);
   end

   assign is_final_beat = (beat_cnt_reg == total_beats_reg - BEAT_W'(1));
   assign exp_mask      = is_final_beat ? last_mask_reg : '1;
   assign lane_ready_o  = (state_reg == ST_COLLECT) && !fifo_full;
   assign beat_accept   = lane_ready_o && (lane_valid_i != '0);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_reg       <= ST_IDLE;
         total_beats_reg <= '0;
         beat_cnt_reg    <= '0;
         last_mask_reg   <= '0;
         err_reg         <= 1'b0;
      end else begin
         state_reg       <= state_next;
         total_beats_reg <= total_beats_next;
         beat_cnt_reg    <= beat_cnt_next;
         last_mask_reg   <= last_mask_next;
         err_reg         <= err_next;
      end
   end

   always_comb begin
      state_next       = state_reg;
      total_beats_next = total_beats_reg;
      beat_cnt_next    = beat_cnt_reg;
      last_mask_next   = last_mask_reg;
      err_next         = err_reg;
      case (state_reg)
         ST_IDLE: begin
            if (start_i) begin
               total_beats_next = total_beats_calc;
               last_mask_next   = last_mask_calc;
               beat_cnt_next    = '0;
               err_next         = 1'b0;
               state_next       = (vl_i == '0) ? ST_DONE : ST_COLLECT;
            end
            // Stray lane traffic with no instruction open is always a protocol error.
            if (lane_valid_i != '0) err_next = 1'b1;
         end
         ST_COLLECT: begin
            if (beat_accept) begin
               if (lane_valid_i != exp_mask) err_next = 1'b1;
               beat_cnt_next = beat_cnt_reg + BEAT_W'(1);
               if (is_final_beat) state_next = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (lane_valid_i != '0) err_next = 1'b1;
            if (fifo_empty) state_next = ST_DONE;
         end
         ST_DONE: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // The strobe is what vl implies, never the received mask, so a bad sender
   // cannot widen the write.
   assign fifo_push = beat_accept;
   assign fifo_din  = {lane_data_i, exp_mask, is_final_beat};
   assign fifo_pop  = out_valid_o && out_ready_i;

   vrc_fifo2 #(
      .WIDTH (ENTRY_W)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (fifo_push),
      .data_i  (fifo_din),
      .pop_i   (fifo_pop),
      .data_o  (fifo_dout),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign out_valid_o = !fifo_empty;
   assign out_data_o  = fifo_empty ? '0 : fifo_dout[ENTRY_W-1 -: BUS_W];
   assign out_strb_o  = fifo_empty ? '0 : fifo_dout[VLANE_NUM:1];
   assign out_last_o  = !fifo_empty && fifo_dout[0];

   assign busy_o = (state_reg != ST_IDLE);
   assign done_o = (state_reg == ST_DONE);
   assign err_o  = err_reg;

endmodule
